uart_config_rx: RTL

UART_CONFIG_RX -- requirements
Module: uart_config_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_config_rx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART configuration receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int WORD_BYTES = 4;

    localparam logic [31:0] DESYNC_WORD = 32'h0010_0000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_r;

    // Shift the async input through two flops
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {2{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[0], d};
        end
    end

    assign q = sync_r[1];

endmodule

// File: rtl/uart_config_rx.sv
// 8N1 UART receiver with activity LED stretch; optional 32-bit word assembler
// enabled by defining UART_RX_WORD_EN.
module uart_config_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 5,
    parameter int LED_HOLD_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        framing_error,
    output logic        rx_led
`ifdef UART_RX_WORD_EN
    ,
    output logic [31:0] word_data,
    output logic        word_valid
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int LED_W = $clog2(LED_HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [LED_W-1:0] LED_LOAD  = LED_W'(LED_HOLD_CYCLES);

    logic              rx_s;
    uart_state_e       state_r, state_nxt;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt;
    logic [2:0]        bit_idx_r, bit_idx_nxt;
    logic [7:0]        shift_r, shift_nxt;
    logic              wait_high_r, wait_high_nxt;
    logic              byte_load_s;
    logic              frame_err_s;
    logic [LED_W-1:0]  led_cnt_r, led_cnt_nxt;
    logic [7:0]        byte_data_r;
    logic              byte_valid_r;
    logic              framing_error_r;
    logic              rx_led_r;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state and datapath decode for the receive FSM
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        bit_idx_nxt   = bit_idx_r;
        shift_nxt     = shift_r;
        wait_high_nxt = wait_high_r;
        byte_load_s   = 1'b0;
        frame_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // After a break the line must go high before a new start is accepted
                if (rx_s) begin
                    wait_high_nxt = 1'b0;
                end else begin
                    wait_high_nxt = wait_high_r;
                end
                if (!rx_s && !wait_high_r) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = 3'd0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift_r[7:1]};
                    if (bit_idx_r == IDX_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        byte_load_s = 1'b1;
                    end else begin
                        frame_err_s   = 1'b1;
                        wait_high_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // LED hold counter: reload alongside byte_valid, count down to zero
    always_comb begin
        led_cnt_nxt = led_cnt_r;
        if (byte_load_s) begin
            led_cnt_nxt = LED_LOAD;
        end else if (led_cnt_r != '0) begin
            led_cnt_nxt = led_cnt_r - LED_W'(1);
        end else begin
            led_cnt_nxt = '0;
        end
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            cnt_r           <= '0;
            bit_idx_r       <= 3'd0;
            shift_r         <= 8'd0;
            wait_high_r     <= 1'b0;
            led_cnt_r       <= '0;
            byte_data_r     <= 8'd0;
            byte_valid_r    <= 1'b0;
            framing_error_r <= 1'b0;
            rx_led_r        <= 1'b0;
        end else begin
            state_r         <= state_nxt;
            cnt_r           <= cnt_nxt;
            bit_idx_r       <= bit_idx_nxt;
            shift_r         <= shift_nxt;
            wait_high_r     <= wait_high_nxt;
            led_cnt_r       <= led_cnt_nxt;
            byte_valid_r    <= byte_load_s;
            framing_error_r <= frame_err_s;
            rx_led_r        <= (state_nxt != IDLE) || (led_cnt_nxt != '0);
            if (byte_load_s) begin
                byte_data_r <= shift_r;
            end else begin
                byte_data_r <= byte_data_r;
            end
        end
    end

    assign byte_data     = byte_data_r;
    assign byte_valid    = byte_valid_r;
    assign framing_error = framing_error_r;
    assign rx_led        = rx_led_r;

`ifdef UART_RX_WORD_EN
    logic [23:0] word_acc_r;
    logic [1:0]  byte_cnt_r;
    logic [31:0] word_data_r;
    logic        word_valid_r;

    // Pack bytes MSB-first; a framing error drops any partial word
    always_ff @(posedge clk) begin
        if (reset) begin
            word_acc_r   <= 24'd0;
            byte_cnt_r   <= 2'd0;
            word_data_r  <= 32'd0;
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
            if (framing_error_r) begin
                byte_cnt_r <= 2'd0;
                word_acc_r <= 24'd0;
            end else if (byte_valid_r) begin
                word_acc_r <= {word_acc_r[15:0], byte_data_r};
                if (byte_cnt_r == 2'(WORD_BYTES - 1)) begin
                    word_data_r  <= {word_acc_r, byte_data_r};
                    word_valid_r <= 1'b1;
                    byte_cnt_r   <= 2'd0;
                end else begin
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                end
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end
        end
    end

    assign word_data  = word_data_r;
    assign word_valid = word_valid_r;
`endif

endmodule
